pontuacao_n: RTL and testbench
==============================

PONTUACAO_N -- requirements
Module: pontuacao_n

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players, range 2..8.
REQ-002 Parameter WIN_SCORE, default 3, round wins needed to win the match, range 1..LED_W/NUM_PLAYERS.
REQ-003 Parameter LED_W, default 16, LED bus width.
REQ-004 Parameter HOLD_CYC, default 4, cycles in which wins are ignored after a scored point, range 1..2^16-1.
REQ-005 Parameter BLINK_DIV, default 50_000_000, clock cycles per blink half-period.
REQ-006 clock  in  1  system clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 win  in  NUM_PLAYERS  per-player round-win request, bit i = player i, level or pulse.
REQ-009 new_match  in  1  synchronous request to clear scores and start a new match.
REQ-010 LED  out  LED_W  per-player score bars.
REQ-011 score  out  NUM_PLAYERS*SCORE_W  packed scores, player i at field i; SCORE_W = clog2(WIN_SCORE+1).
REQ-012 match_over  out  1  high while a match winner is latched.
REQ-013 winner  out  PID_W  winning player index, PID_W = max(1, clog2(NUM_PLAYERS)).
REQ-014 round_lock  out  1  high in HOLD and OVER; the game engine stalls while high.

Function
REQ-015 Per-bit rising-edge detection on win: a bit held high counts once; rise_i = win_i AND NOT win_q_i.
REQ-016 States are PLAY, HOLD and OVER.
REQ-017 PLAY: on any rise, the lowest-index rising player gets +1 score at that clock edge; other simultaneous rises are discarded.
REQ-018 PLAY: if that increment makes score equal WIN_SCORE, go to OVER and latch winner; otherwise go to HOLD with the hold counter loaded to HOLD_CYC-1.
REQ-019 HOLD: all rises ignored; counter decrements each cycle; at 0, go to PLAY on the next edge; HOLD lasts exactly HOLD_CYC cycles.
REQ-020 OVER: rises ignored; scores, winner and match_over held.
REQ-021 new_match in any state: clear all scores, set winner to 0, drop match_over, go to PLAY at the next edge; it has priority over a simultaneous rise.
REQ-022 Scores saturate at WIN_SCORE and never wrap.
REQ-023 Latency: score, LED and match_over change one cycle after the win edge is sampled.
REQ-024 LED field F = LED_W/NUM_PLAYERS; player i owns LED[(i+1)*F-1 : i*F]; thermometer code from the field LSB; score k lights the k lowest bits; unused MSBs of LED are 0.

Reset
REQ-025 reset clears state to PLAY, scores, winner, LED, match_over, round_lock, win_q, hold counter and blink counter to 0, asynchronously.
REQ-026 reset while HOLD or OVER is active discards the pending state completely; the first rise after reset release is counted.

Configuration
REQ-027 Macro PONTUACAO_BLINK_EN defined: in OVER, the winner's LED field toggles every BLINK_DIV cycles, starting lit on OVER entry; other players' fields stay steady.
REQ-028 Macro PONTUACAO_BLINK_EN undefined: the winner's field stays steady, and no blink counter is synthesised.

Structure
REQ-029 Package pontuacao_pkg holds the state enum (PLAY, HOLD, OVER) and the function computing the LED thermometer mask.
REQ-030 Sub-module win_edge_det, parametrised by width, provides the registered rising-edge detection for REQ-015.

Verification
Bench parameters: NUM_PLAYERS=2, WIN_SCORE=3, LED_W=16, HOLD_CYC=4, BLINK_DIV=8.
REQ-031 Reset, then win=01 for 1 cycle -> score0=1, LED=0x0001, round_lock high for exactly 4 cycles.
REQ-032 win=11 in the same cycle -> only player 0 scores; score1 stays 0.
REQ-033 win=10 held high for 20 cycles -> score1=1, LED=0x0100, counted once.
REQ-034 Three spaced player-1 wins -> match_over=1, winner=1, LED=0x0700; further wins leave everything unchanged; with BLINK_EN, LED[15:8] alternates 0x07/0x00 every 8 cycles.
REQ-035 new_match together with win=01 while in OVER -> all scores 0, match_over=0, state PLAY, no point counted.
REQ-036 reset asserted mid-HOLD -> all outputs 0 immediately; after release, the next win is counted without a hold.

Source files
------------

// File: rtl/pontuacao_pkg.sv
// ---------------------------------------------------------------------------
// pontuacao_pkg
// Shared definitions for the pontuacao_n scoreboard:
//   state_t      : match state (PLAY, HOLD, OVER)
//   MASK_W       : widest LED field the thermometer helper can produce
//   thermo_mask  : returns a mask with the k lowest bits set
// ---------------------------------------------------------------------------
package pontuacao_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int MASK_W = 32;

    // Thermometer code: a score of k lights the k lowest bits of a field.
    function automatic logic [MASK_W-1:0] thermo_mask(input logic [7:0] k);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int j = 0; j < MASK_W; j++) begin
            m[j] = (j < int'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/pontuacao_n_win_edge_det.sv
// ---------------------------------------------------------------------------
// win_edge_det
// Registered per-bit rising-edge detector. A bit that stays high produces a
// single-cycle rise; the first high sample after reset counts as a rise.
// Ports:
//   clock : system clock (rising edge)
//   reset : asynchronous active-high reset, clears the history register
//   din   : W-bit level/pulse input
//   rise  : W-bit rising-edge flags, din & ~previous din
// ---------------------------------------------------------------------------
module win_edge_det #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] din_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            din_q <= '0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/pontuacao_n.sv
// ---------------------------------------------------------------------------
// pontuacao_n
// Multi-player match scoreboard. Counts round wins per player, enforces a
// hold-off after every point, latches the match winner and drives per-player
// thermometer LED bars.
// Optional feature macro: PONTUACAO_BLINK_EN -- when defined, the winner's
// LED field blinks (BLINK_DIV cycles per half-period) while the match is over.
// Ports:
//   clock      : system clock (rising edge)
//   reset      : asynchronous active-high reset
//   win        : per-player round-win request, bit i = player i
//   new_match  : synchronous clear of scores / winner, back to PLAY
//   LED        : per-player score bars, field F = LED_W/NUM_PLAYERS
//   score      : packed scores, player i at field i
//   match_over : high while a winner is latched
//   winner     : index of the winning player
//   round_lock : high in HOLD and OVER
// ---------------------------------------------------------------------------
module pontuacao_n
    import pontuacao_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int WIN_SCORE   = 3,
    parameter int LED_W       = 16,
    parameter int HOLD_CYC    = 4,
    parameter int BLINK_DIV   = 50_000_000,
    localparam int SCORE_W    = $clog2(WIN_SCORE + 1),
    localparam int PID_W      = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PLAYERS-1:0]         win,
    input  logic                           new_match,
    output logic [LED_W-1:0]               LED,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           match_over,
    output logic [PID_W-1:0]               winner,
    output logic                           round_lock
);

    localparam int F = LED_W / NUM_PLAYERS;

    state_t                                 state, state_nxt;
    logic [15:0]                            hold_cnt, hold_nxt;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_r, score_nxt;
    logic [PID_W-1:0]                       winner_r, winner_nxt;
    logic                                   over_r, over_nxt;
    logic [NUM_PLAYERS-1:0]                 rise;
    logic                                   hit;
    logic [PID_W-1:0]                       hit_id;
    logic [SCORE_W-1:0]                     inc;
    logic                                   blink_off;

    // Saturating increment: a score never moves past WIN_SCORE.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s >= SCORE_W'(WIN_SCORE)) begin
            return s;
        end
        return s + SCORE_W'(1);
    endfunction

    win_edge_det #(.W(NUM_PLAYERS)) u_edge (
        .clock (clock),
        .reset (reset),
        .din   (win),
        .rise  (rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PLAY;
            hold_cnt <= '0;
            score_r  <= '0;
            winner_r <= '0;
            over_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            score_r  <= score_nxt;
            winner_r <= winner_nxt;
            over_r   <= over_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        score_nxt  = score_r;
        winner_nxt = winner_r;
        over_nxt   = over_r;
        hit        = 1'b0;
        hit_id     = '0;

        // Scan high to low so the lowest-index rising player wins the tie.
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                hit    = 1'b1;
                hit_id = PID_W'(i);
            end
        end
        inc = sat_inc(score_r[hit_id]);

        if (new_match) begin
            state_nxt  = PLAY;
            hold_nxt   = '0;
            score_nxt  = '0;
            winner_nxt = '0;
            over_nxt   = 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (hit) begin
                        score_nxt[hit_id] = inc;
                        if (inc == SCORE_W'(WIN_SCORE)) begin
                            state_nxt  = OVER;
                            winner_nxt = hit_id;
                            over_nxt   = 1'b1;
                        end else begin
                            state_nxt = HOLD;
                            hold_nxt  = 16'(HOLD_CYC - 1);
                        end
                    end
                end
                HOLD: begin
                    // Counter runs HOLD_CYC-1 down to 0, one cycle each.
                    if (hold_cnt == 16'd0) begin
                        state_nxt = PLAY;
                    end else begin
                        hold_nxt = hold_cnt - 16'd1;
                    end
                end
                OVER: begin
                end
                default: begin
                    state_nxt = PLAY;
                end
            endcase
        end
    end

`ifdef PONTUACAO_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    logic [BLINK_W-1:0] blink_cnt;

    // Phase restarts (lit) every time OVER is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state != OVER) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        logic [MASK_W-1:0] mask;
        mask = '0;
        LED  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            mask = thermo_mask(8'(score_r[i]));
            if (blink_off && (state == OVER) && (winner_r == PID_W'(i))) begin
                mask = '0;
            end
            LED[i*F +: F] = mask[F-1:0];
        end
    end

    assign score      = score_r;
    assign match_over = over_r;
    assign winner     = winner_r;
    assign round_lock = (state != PLAY);

endmodule

// File: tb/tb_pontuacao_n.sv
// ---------------------------------------------------------------------------
// tb_pontuacao_n
// Directed bench for pontuacao_n with NUM_PLAYERS=2, WIN_SCORE=3, LED_W=16,
// HOLD_CYC=4, BLINK_DIV=8. Expected outputs are queued when a step is driven
// and compared after the following clock edge.
// ---------------------------------------------------------------------------
module tb_pontuacao_n;

    localparam int NP = 2;
    localparam int WS = 3;
    localparam int LW = 16;
    localparam int SW = $clog2(WS + 1);

    logic              clock;
    logic              reset;
    logic [NP-1:0]     win;
    logic              new_match;
    logic [LW-1:0]     LED;
    logic [NP*SW-1:0]  score;
    logic              match_over;
    logic [0:0]        winner;
    logic              round_lock;

    int vectors;
    int miscompares;

    typedef struct {
        string       tag;
        logic [3:0]  sc;
        logic [15:0] led;
        logic        ov;
        logic        w;
        logic        lk;
    } exp_t;

    exp_t sb[$];

    pontuacao_n #(
        .NUM_PLAYERS (NP),
        .WIN_SCORE   (WS),
        .LED_W       (LW),
        .HOLD_CYC    (4),
        .BLINK_DIV   (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .win        (win),
        .new_match  (new_match),
        .LED        (LED),
        .score      (score),
        .match_over (match_over),
        .winner     (winner),
        .round_lock (round_lock)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] sc, input logic [15:0] led,
                        input logic ov, input logic w, input logic lk);
        exp_t e;
        e.tag = tag; e.sc = sc; e.led = led; e.ov = ov; e.w = w; e.lk = lk;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, "_score"}, 32'(score), 32'(e.sc));
            cmp({e.tag, "_led"}, 32'(LED), 32'(e.led));
            cmp({e.tag, "_over"}, 32'(match_over), 32'(e.ov));
            cmp({e.tag, "_winner"}, 32'(winner), 32'(e.w));
            cmp({e.tag, "_lock"}, 32'(round_lock), 32'(e.lk));
        end
    endtask

    logic [15:0] blink_led;
    int          lock_n;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        win         = '0;
        new_match   = 1'b0;
`ifdef PONTUACAO_BLINK_EN
        blink_led = 16'h0000;
`else
        blink_led = 16'h0700;
`endif

        // Reset state
        tick(2);
        push("reset", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_out();
        reset = 1'b0;
        tick();

        // Single pulse for player 0, then measure hold length
        win = 2'b01;
        push("p0_first", 4'h1, 16'h0001, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        win = 2'b00;
        lock_n = 0;
        for (int k = 0; k < 10; k++) begin
            if (!round_lock) break;
            lock_n++;
            tick();
        end
        cmp("hold_len", 32'(lock_n), 32'd4);

        // Simultaneous rises: only player 0 scores
        win = 2'b11;
        push("tie", 4'h2, 16'h0003, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        win = 2'b00;
        tick(4);
        cmp("tie_unlock", 32'(round_lock), 32'd0);

        // new_match in PLAY clears scores
        new_match = 1'b1;
        push("nm_play", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_out();
        new_match = 1'b0;

        // Player 1 held high for 20 cycles counts once
        win = 2'b10;
        push("p1_held", 4'h4, 16'h0100, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        push("p1_held_end", 4'h4, 16'h0100, 1'b0, 1'b0, 1'b0);
        tick(19);
        check_out();
        win = 2'b00;
        tick();

        // Two more spaced player-1 wins finish the match
        win = 2'b10;
        push("p1_second", 4'h8, 16'h0300, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        win = 2'b00;
        tick(5);
        win = 2'b10;
        push("p1_match", 4'hC, 16'h0700, 1'b1, 1'b1, 1'b1);
        tick();
        check_out();
        win = 2'b00;

        // Wins during OVER are ignored; blink phase checked at cycles 8 and 9
        win = 2'b01;
        tick();
        win = 2'b10;
        tick();
        win = 2'b00;
        tick(4);
        push("over_lit", 4'hC, 16'h0700, 1'b1, 1'b1, 1'b1);
        tick();
        check_out();
        push("over_blink", 4'hC, blink_led, 1'b1, 1'b1, 1'b1);
        tick();
        check_out();

        // new_match with a simultaneous rise while OVER
        new_match = 1'b1;
        win       = 2'b01;
        push("nm_over", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_out();
        new_match = 1'b0;
        win       = 2'b00;
        push("nm_over_after", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_out();

        // Reset in the middle of HOLD
        win = 2'b01;
        push("pre_rst", 4'h1, 16'h0001, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        win = 2'b00;
        tick();
        reset = 1'b1;
        #2;
        push("rst_async", 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check_out();
        tick();
        reset = 1'b0;
        cmp("post_rst_lock", 32'(round_lock), 32'd0);
        win = 2'b01;
        push("post_rst_win", 4'h1, 16'h0001, 1'b0, 1'b0, 1'b1);
        tick();
        check_out();
        win = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
